// File: rtl/write_master.sv
// AXI4 write-side DMA engine: drains an FWFT FIFO into INCR bursts of at most
// 16 x 32-bit beats, never crossing a 4 KB boundary, one burst outstanding.
module write_master #(
  parameter int C_M_AXI_ID_WIDTH   = 1,
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          i_start,
  input  logic [31:0]                   i_dst_addr,
  input  logic [31:0]                   i_total_len,
  output logic                          o_write_done,
  output logic                          o_write_err,
  input  logic                          i_fifo_empty,
  input  logic [31:0]                   i_w_data,
  output logic                          o_fifo_pop,
  output logic [C_M_AXI_ID_WIDTH-1:0]   m_axi_awid,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]                    m_axi_awlen,
  output logic [2:0]                    m_axi_awsize,
  output logic [1:0]                    m_axi_awburst,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_wdata,
  output logic [3:0]                    m_axi_wstrb,
  output logic                          m_axi_wlast,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  input  logic [1:0]                    m_axi_bresp,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready
);

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_ADDR = 4'b0010,
    S_DATA = 4'b0100,
    S_RESP = 4'b1000
  } state_t;

  state_t      r_state, w_next;
  logic [31:0] r_addr, r_remaining;
  logic [4:0]  r_beats, r_beat_cnt;
  logic        r_awvalid, r_done, r_err;

  logic [31:0] w_start_len, w_step, w_rem_next;
  logic [12:0] w_to_bound;
  logic [6:0]  w_cap, w_bytes;
  logic        w_aw_hs, w_w_hs, w_last, w_wvalid, w_bready, w_pop;
  logic        w_unused_ok;

  // Length is counted in whole words; the two low bits carry no information.
  assign w_start_len = {i_total_len[31:2], 2'b00};
  assign w_unused_ok = &{1'b0, i_total_len[1:0]};

  // Burst size: min(remaining, 64, bytes left in the current 4 KB page).
  // Recomputed from registers, so it stays stable while awvalid is held.
  assign w_to_bound = 13'h1000 - {1'b0, r_addr[11:0]};
  assign w_cap      = (r_remaining < 32'd64) ? r_remaining[6:0] : 7'd64;
  assign w_bytes    = ({6'd0, w_cap} < w_to_bound) ? w_cap : w_to_bound[6:0];

  // Bytes retired by the burst just completed.
  assign w_step     = {25'd0, r_beats, 2'b00};
  assign w_rem_next = r_remaining - w_step;

  assign w_aw_hs = r_awvalid & m_axi_awready;
  assign w_w_hs  = w_wvalid & m_axi_wready;
  assign w_last  = (r_beat_cnt == r_beats - 5'd1);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state and channel handshake outputs.
  always_comb begin
    w_next   = r_state;
    w_wvalid = 1'b0;
    w_bready = 1'b0;
    w_pop    = 1'b0;
    unique case (r_state)
      S_IDLE: if (i_start && (w_start_len != 32'd0)) w_next = S_ADDR;
      S_ADDR: if (w_aw_hs) w_next = S_DATA;
      S_DATA: begin
        w_wvalid = !i_fifo_empty;
        w_pop    = w_wvalid & m_axi_wready;
        if (w_pop && w_last) w_next = S_RESP;
      end
      S_RESP: begin
        w_bready = 1'b1;
        if (m_axi_bvalid) w_next = (w_rem_next == 32'd0) ? S_IDLE : S_ADDR;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Address/length bookkeeping, beat counting, done pulse and sticky error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr      <= '0;
      r_remaining <= '0;
      r_beats     <= '0;
      r_beat_cnt  <= '0;
      r_awvalid   <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (i_start) begin
          r_addr      <= i_dst_addr;
          r_remaining <= w_start_len;
          r_err       <= 1'b0;
          if (w_start_len == 32'd0) r_done    <= 1'b1;
          else                      r_awvalid <= 1'b1;
        end
        S_ADDR: if (w_aw_hs) begin
          r_awvalid  <= 1'b0;
          r_beats    <= w_bytes[6:2];
          r_beat_cnt <= '0;
        end
        S_DATA: if (w_w_hs) r_beat_cnt <= r_beat_cnt + 5'd1;
        S_RESP: if (m_axi_bvalid) begin
          r_addr      <= r_addr + w_step;
          r_remaining <= w_rem_next;
          if (m_axi_bresp != 2'b00) r_err <= 1'b1;
          // Look-ahead: raise awvalid for the next burst on the B edge.
          if (w_rem_next == 32'd0) r_done    <= 1'b1;
          else                     r_awvalid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign m_axi_awid    = '0;
  assign m_axi_awaddr  = r_addr;
  assign m_axi_awlen   = (w_bytes == 7'd0) ? 8'd0 : ({3'd0, w_bytes[6:2]} - 8'd1);
  assign m_axi_awsize  = 3'b010;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_wdata   = i_w_data;
  assign m_axi_wstrb   = 4'hF;
  assign m_axi_wlast   = (r_state == S_DATA) & w_last;
  assign m_axi_wvalid  = w_wvalid;
  assign m_axi_bready  = w_bready;
  assign o_fifo_pop    = w_pop;
  assign o_write_done  = r_done;
  assign o_write_err   = r_err;

endmodule

// File: tb/tb_write_master.sv
// Directed bench for write_master: FWFT FIFO model and AXI write slave driven
// cycle by cycle, with inline checks in one task per scenario.
module tb_write_master;
  logic        clk = 1'b0, reset_n = 1'b1;
  logic        i_start = 1'b0;
  logic [31:0] i_dst_addr = '0, i_total_len = '0;
  logic        o_write_done, o_write_err;
  logic        i_fifo_empty = 1'b1;
  logic [31:0] i_w_data = '0;
  logic        o_fifo_pop;
  logic [0:0]  m_axi_awid;
  logic [31:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awvalid, m_axi_awready = 1'b0;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wlast, m_axi_wvalid, m_axi_wready = 1'b0;
  logic [1:0]  m_axi_bresp = 2'b00;
  logic        m_axi_bvalid = 1'b0, m_axi_bready;

  write_master dut (
    .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_dst_addr(i_dst_addr),
    .i_total_len(i_total_len), .o_write_done(o_write_done), .o_write_err(o_write_err),
    .i_fifo_empty(i_fifo_empty), .i_w_data(i_w_data), .o_fifo_pop(o_fifo_pop),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0, cyc = 0;
  logic [31:0] fifo_q[$];
  logic [31:0] aw_addr_q[$];
  logic [7:0]  aw_len_q[$];
  logic [1:0]  bresp_tab[8];
  int aw_cnt, w_cnt, wlast_cnt, b_cnt, pop_cnt, done_cnt, done_cyc, bhs_cyc;
  int first_w_cyc, last_w_cyc, seq_err, wlast_err, data_err, pop_err;
  int aw_unstable, bad_wvalid, aw_stall, beat_in_burst;
  int awready_delay, aw_wait, empty_at, empty_len, empty_left;
  logic [7:0]  cur_awlen, prev_awlen;
  logic [31:0] exp_word, prev_awaddr;
  logic        b_pending, start_req, err_at_aw3, prev_aw_waiting;

  task automatic clear_model();
    fifo_q.delete(); aw_addr_q.delete(); aw_len_q.delete();
    foreach (bresp_tab[i]) bresp_tab[i] = 2'b00;
    aw_cnt = 0; w_cnt = 0; wlast_cnt = 0; b_cnt = 0; pop_cnt = 0; done_cnt = 0;
    done_cyc = -1; bhs_cyc = -100; first_w_cyc = 0; last_w_cyc = 0;
    seq_err = 0; wlast_err = 0; data_err = 0; pop_err = 0; aw_unstable = 0;
    bad_wvalid = 0; aw_stall = 0; beat_in_burst = 0; awready_delay = 0; aw_wait = 0;
    empty_at = -1; empty_len = 0; empty_left = 0; cur_awlen = 0; exp_word = 0;
    b_pending = 0; start_req = 0; err_at_aw3 = 0; prev_aw_waiting = 0;
  endtask

  task automatic fill_fifo(input int n, input logic [31:0] base);
    exp_word = base;
    for (int i = 0; i < n; i++) fifo_q.push_back(base + i);
  endtask

  // One clock: drive inputs at negedge, observe settled outputs, update model
  // after the posedge on which the observed handshakes take place.
  task automatic step();
    logic aw_hs, w_hs, b_hs, pop, wl;
    @(negedge clk);
    i_start       = start_req;
    m_axi_awready = (aw_wait >= awready_delay);
    i_fifo_empty  = (fifo_q.size() == 0) || (empty_left > 0);
    i_w_data      = (fifo_q.size() != 0) ? fifo_q[0] : 32'hDEAD_BEEF;
    m_axi_wready  = 1'b1;
    m_axi_bvalid  = b_pending;
    m_axi_bresp   = b_pending ? bresp_tab[b_cnt % 8] : 2'b00;
    #1;
    aw_hs = m_axi_awvalid && m_axi_awready;
    w_hs  = m_axi_wvalid && m_axi_wready;
    b_hs  = m_axi_bvalid && m_axi_bready;
    pop   = o_fifo_pop;
    wl    = m_axi_wlast;
    if (prev_aw_waiting && (!m_axi_awvalid || m_axi_awaddr !== prev_awaddr ||
        m_axi_awlen !== prev_awlen)) aw_unstable++;
    prev_aw_waiting = m_axi_awvalid && !m_axi_awready;
    prev_awaddr = m_axi_awaddr; prev_awlen = m_axi_awlen;
    if (m_axi_wvalid && i_fifo_empty) bad_wvalid++;
    if (pop !== w_hs) pop_err++;
    if (pop) pop_cnt++;
    if (o_write_done) begin done_cnt++; done_cyc = cyc; end
    if (aw_hs) begin
      if (aw_cnt != b_cnt) seq_err++;
      if (aw_cnt == 2) err_at_aw3 = o_write_err;
      aw_addr_q.push_back(m_axi_awaddr); aw_len_q.push_back(m_axi_awlen);
      cur_awlen = m_axi_awlen; beat_in_burst = 0; aw_cnt++; aw_wait = 0;
    end else if (m_axi_awvalid) begin
      aw_wait++; aw_stall++;
    end
    if (w_hs) begin
      if (aw_cnt != wlast_cnt + 1) seq_err++;
      if (wl !== (beat_in_burst == int'(cur_awlen))) wlast_err++;
      if (m_axi_wdata !== exp_word) data_err++;
      exp_word++;
      if (w_cnt == 0) first_w_cyc = cyc;
      last_w_cyc = cyc; w_cnt++; beat_in_burst++;
      if (wl) wlast_cnt++;
    end
    if (b_hs) bhs_cyc = cyc;
    @(posedge clk);
    cyc++;
    start_req = 1'b0;
    if (pop && fifo_q.size() != 0) void'(fifo_q.pop_front());
    if (empty_left > 0) empty_left--;
    if (w_hs && w_cnt == empty_at) empty_left = empty_len;
    if (w_hs && wl) b_pending = 1'b1;
    if (b_hs) begin b_pending = 1'b0; b_cnt++; end
  endtask

  task automatic start_xfer(input logic [31:0] addr, input logic [31:0] len);
    i_dst_addr = addr; i_total_len = len; start_req = 1'b1;
    step();
  endtask

  task automatic run_until_done(input int budget, input string name);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin step(); n++; end
    tests++;
    if (done_cnt == 0) begin
      fails++; $display("FAIL %s timeout: no done within %0d cycles", name, budget);
    end
  endtask

  task automatic test_reset();
    clear_model();
    #1 reset_n = 1'b0;
    repeat (3) step();
    tests++;
    if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, o_fifo_pop, o_write_done, o_write_err, m_axi_wlast} !== 7'b0) begin
      fails++; $display("FAIL reset_ctrl: got %b expected 0000000",
        {m_axi_awvalid, m_axi_wvalid, m_axi_bready, o_fifo_pop, o_write_done, o_write_err, m_axi_wlast});
    end
    tests++;
    if ({m_axi_awaddr, m_axi_awlen} !== 40'h0) begin
      fails++; $display("FAIL reset_aw: got %h/%h expected 0/0", m_axi_awaddr, m_axi_awlen);
    end
    tests++;
    if ({m_axi_awid, m_axi_awsize, m_axi_awburst, m_axi_wstrb} !== {1'b0, 3'b010, 2'b01, 4'hF}) begin
      fails++; $display("FAIL reset_const: got %b expected 0010011111",
        {m_axi_awid, m_axi_awsize, m_axi_awburst, m_axi_wstrb});
    end
    @(posedge clk); #2 reset_n = 1'b1;
    repeat (2) step();
    tests++;
    if (m_axi_awvalid !== 1'b0 || o_write_done !== 1'b0) begin
      fails++; $display("FAIL post_reset_idle: awvalid %b done %b expected 0 0", m_axi_awvalid, o_write_done);
    end
  endtask

  task automatic test_single();
    clear_model(); fill_fifo(16, 32'hA000_0000);
    start_xfer(32'h0000_2000, 32'd64);
    run_until_done(200, "single");
    repeat (2) step();
    tests++; if (aw_cnt !== 1) begin fails++; $display("FAIL single_aw_cnt: got %0d expected 1", aw_cnt); end
    tests++; if (aw_addr_q[0] !== 32'h2000) begin fails++; $display("FAIL single_awaddr: got %h expected 00002000", aw_addr_q[0]); end
    tests++; if (aw_len_q[0] !== 8'd15) begin fails++; $display("FAIL single_awlen: got %0d expected 15", aw_len_q[0]); end
    tests++; if (w_cnt !== 16 || wlast_cnt !== 1 || wlast_err !== 0) begin
      fails++; $display("FAIL single_beats: beats %0d wlast %0d wlast_err %0d expected 16 1 0", w_cnt, wlast_cnt, wlast_err); end
    tests++; if (pop_cnt !== 16 || pop_err !== 0) begin fails++; $display("FAIL single_pops: got %0d (err %0d) expected 16 (0)", pop_cnt, pop_err); end
    tests++; if (done_cyc !== bhs_cyc + 1) begin fails++; $display("FAIL single_done_timing: done at %0d expected %0d", done_cyc, bhs_cyc + 1); end
    tests++; if (done_cnt !== 1) begin fails++; $display("FAIL single_done_pulse: got %0d pulses expected 1", done_cnt); end
    tests++; if (data_err !== 0) begin fails++; $display("FAIL single_data: got %0d bad words expected 0", data_err); end
  endtask

  task automatic test_multi();
    logic [31:0] exp_a[4] = '{32'h1000, 32'h1040, 32'h1080, 32'h10C0};
    clear_model(); fill_fifo(64, 32'hB000_0000);
    start_xfer(32'h0000_1000, 32'd256);
    run_until_done(400, "multi");
    tests++; if (aw_cnt !== 4) begin fails++; $display("FAIL multi_aw_cnt: got %0d expected 4", aw_cnt); end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (aw_addr_q[i] !== exp_a[i] || aw_len_q[i] !== 8'd15) begin
        fails++; $display("FAIL multi_aw%0d: got %h/%0d expected %h/15", i, aw_addr_q[i], aw_len_q[i], exp_a[i]);
      end
    end
    tests++; if (pop_cnt !== 64) begin fails++; $display("FAIL multi_pops: got %0d expected 64", pop_cnt); end
    tests++; if (seq_err !== 0 || data_err !== 0) begin fails++; $display("FAIL multi_order: seq %0d data %0d expected 0 0", seq_err, data_err); end
  endtask

  task automatic test_split();
    clear_model(); fill_fifo(8, 32'hC000_0000);
    start_xfer(32'h0000_0FF8, 32'd32);
    run_until_done(200, "split");
    tests++; if (aw_cnt !== 2) begin fails++; $display("FAIL split_aw_cnt: got %0d expected 2", aw_cnt); end
    tests++; if (aw_addr_q[0] !== 32'h0FF8 || aw_len_q[0] !== 8'd1) begin
      fails++; $display("FAIL split_aw0: got %h/%0d expected 00000ff8/1", aw_addr_q[0], aw_len_q[0]); end
    tests++; if (aw_addr_q[1] !== 32'h1000 || aw_len_q[1] !== 8'd5) begin
      fails++; $display("FAIL split_aw1: got %h/%0d expected 00001000/5", aw_addr_q[1], aw_len_q[1]); end
    tests++; if (w_cnt !== 8 || wlast_cnt !== 2 || wlast_err !== 0) begin
      fails++; $display("FAIL split_beats: beats %0d wlast %0d err %0d expected 8 2 0", w_cnt, wlast_cnt, wlast_err); end
  endtask

  task automatic test_backpressure();
    clear_model(); fill_fifo(16, 32'hD000_0000);
    awready_delay = 3; empty_at = 5; empty_len = 5;
    start_xfer(32'h0000_3000, 32'd64);
    run_until_done(200, "bp");
    tests++; if (aw_stall !== 3 || aw_unstable !== 0) begin
      fails++; $display("FAIL bp_aw_hold: stall %0d unstable %0d expected 3 0", aw_stall, aw_unstable); end
    tests++; if (bad_wvalid !== 0) begin fails++; $display("FAIL bp_wvalid_empty: got %0d expected 0", bad_wvalid); end
    tests++; if (last_w_cyc - first_w_cyc !== 20) begin
      fails++; $display("FAIL bp_span: got %0d cycles expected 20", last_w_cyc - first_w_cyc); end
    tests++; if (pop_cnt !== 16 || data_err !== 0 || fifo_q.size() !== 0) begin
      fails++; $display("FAIL bp_data: pops %0d data_err %0d left %0d expected 16 0 0", pop_cnt, data_err, fifo_q.size()); end
  endtask

  task automatic test_error_and_zero();
    clear_model(); fill_fifo(48, 32'hE000_0000);
    bresp_tab[1] = 2'b10;
    start_xfer(32'h0000_4000, 32'd192);
    run_until_done(400, "err");
    repeat (2) step();
    tests++; if (aw_cnt !== 3) begin fails++; $display("FAIL err_aw_cnt: got %0d expected 3", aw_cnt); end
    tests++; if (err_at_aw3 !== 1'b1) begin fails++; $display("FAIL err_set_before_burst3: got %b expected 1", err_at_aw3); end
    tests++; if (o_write_err !== 1'b1 || done_cnt !== 1) begin
      fails++; $display("FAIL err_sticky_done: err %b done %0d expected 1 1", o_write_err, done_cnt); end
    // A start with length 3 rounds down to zero words: clears err, done next cycle.
    clear_model();
    start_xfer(32'h0000_7000, 32'd3);
    step();
    tests++; if (done_cnt !== 1 || o_write_err !== 1'b0 || m_axi_awvalid !== 1'b0) begin
      fails++; $display("FAIL zero_len: done %0d err %b awvalid %b expected 1 0 0", done_cnt, o_write_err, m_axi_awvalid); end
    repeat (2) step();
    tests++; if (done_cnt !== 1 || aw_cnt !== 0) begin
      fails++; $display("FAIL zero_len_quiet: done %0d aw %0d expected 1 0", done_cnt, aw_cnt); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    clear_model(); fill_fifo(16, 32'hF000_0000);
    start_xfer(32'h0000_5000, 32'd64);
    while (w_cnt < 5 && n < 50) begin step(); n++; end
    tests++; if (w_cnt !== 5) begin fails++; $display("FAIL rstmid_reach: got %0d beats expected 5", w_cnt); end
    #2 reset_n = 1'b0;
    #1;
    tests++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, o_fifo_pop} !== 4'b0) begin
      fails++; $display("FAIL rstmid_valids: got %b expected 0000", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, o_fifo_pop}); end
    clear_model();
    repeat (2) step();
    @(posedge clk); #2 reset_n = 1'b1;
    fill_fifo(4, 32'h1234_0000);
    start_xfer(32'h0000_6000, 32'd16);
    run_until_done(100, "rstmid_restart");
    tests++; if (aw_addr_q[0] !== 32'h6000 || aw_len_q[0] !== 8'd3 || w_cnt !== 4 || data_err !== 0) begin
      fails++; $display("FAIL rstmid_restart: aw %h/%0d beats %0d data_err %0d expected 00006000/3 4 0",
        aw_addr_q[0], aw_len_q[0], w_cnt, data_err); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_split();
    test_backpressure();
    test_error_and_zero();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/write_master.md
Name: write_master

Overview:
- AXI4-Full write-side DMA engine. It drains a first-word-fall-through (FWFT) FIFO filled by the read side and writes the data to a destination address range as INCR bursts.
- It splits the transfer into bursts of at most 16 beats × 32 bits and never crosses a 4 KB boundary.
- It completes each burst only after the B response, then pulses a done flag to the DMA controller.

Parameters:
- C_M_AXI_ID_WIDTH, 1, AXI ID width; AWID is driven to 0.
- C_M_AXI_ADDR_WIDTH, 32, AXI address width.
- C_M_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- i_start  in  1  start pulse; sampled only in IDLE
- i_dst_addr  in  32  destination byte address; must be 4-byte aligned
- i_total_len  in  32  byte count; bits [1:0] are ignored
- o_write_done  out  1  one-cycle pulse when the last B response is accepted
- o_write_err  out  1  sticky; set on any BRESP != OKAY, cleared on the next i_start
- i_fifo_empty  in  1  FIFO empty flag
- i_w_data  in  32  FIFO head word (FWFT)
- o_fifo_pop  out  1  FIFO read strobe
- m_axi_awid  out  ID  constant 0
- m_axi_awaddr  out  ADDR  burst start address
- m_axi_awlen  out  8  beats − 1
- m_axi_awsize  out  3  constant 3'b010
- m_axi_awburst  out  2  constant 2'b01 (INCR)
- m_axi_awvalid  out  1  address valid (registered)
- m_axi_awready  in  1  address ready
- m_axi_wdata  out  DATA  equals i_w_data
- m_axi_wstrb  out  4  constant 4'hF
- m_axi_wlast  out  1  last beat of burst
- m_axi_wvalid  out  1  write data valid
- m_axi_wready  in  1  write data ready
- m_axi_bresp  in  2  write response
- m_axi_bvalid  in  1  response valid
- m_axi_bready  out  1  response ready

Behaviour:
- Reset values: every output is 0 except the constants; state = IDLE; address, remaining and beat registers = 0.
- States: IDLE, ADDR, DATA, RESP (one-hot).
- IDLE:
  - On i_start, latch i_dst_addr and {i_total_len[31:2],2'b00}.
  - Clear o_write_err.
  - If the latched length is 0: pulse o_write_done the next cycle and stay in IDLE.
  - Otherwise set awvalid in the same edge and go to ADDR.
- Burst sizing, computed from the current registers:
  - bytes = min(remaining, 64, 0x1000 − addr[11:0]).
  - awlen = bytes/4 − 1.
- ADDR:
  - awaddr and awlen are held stable while awvalid = 1.
  - On awvalid & awready: clear awvalid, register beats = bytes/4, reset the beat counter, go to DATA.
- DATA:
  - wvalid = !i_fifo_empty.
  - o_fifo_pop = wvalid & wready.
  - wlast = (beat_cnt == beats − 1).
  - The beat counter increments on each handshake.
  - An empty FIFO stalls the burst with no bubble penalty beyond the empty cycles.
  - On the last-beat handshake, go to RESP.
- RESP:
  - bready = 1.
  - On bvalid:
    - addr += beats·4.
    - remaining −= beats·4.
    - If bresp != 2'b00, set o_write_err.
    - If remaining hits 0: pulse o_write_done, go to IDLE.
    - Otherwise set awvalid (look-ahead) and go to ADDR.
- AW and W are strictly sequential: no W beat is issued before its AW handshake, and at most one burst is outstanding.
- An error does not abort the transfer; the remaining bursts still execute.
- i_start is ignored outside IDLE.
- Asynchronous reset mid-burst returns to IDLE immediately and drops all valids; the FIFO is not flushed by this block.
- Address arithmetic is 32-bit and wraps modulo 2^32; the boundary rule still prevents crossing 4 KB.

Test Plan:
- Aligned single burst: addr 0x0000_2000, len 64, FIFO pre-filled → one AW with awlen=15; 16 W beats with wlast on beat 16; 16 pops; done pulse one cycle after bvalid.
- Multi-burst: addr 0x1000, len 256, awready/wready always 1 → 4 AWs at 0x1000/0x1040/0x1080/0x10C0, each awlen=15, each following the prior B; exactly 64 pops.
- 4 KB split: addr 0x0FF8, len 32 → AW 0x0FF8 awlen=1, then AW 0x1000 awlen=5; 8 beats total.
- Backpressure: FIFO empty for 5 cycles mid-burst plus awready delayed 3 cycles → awvalid/awaddr held stable; wvalid low while empty; data order preserved; no extra pops.
- Error path: bresp=SLVERR on burst 2 of 3 → o_write_err set and held; burst 3 still issued; done pulses; err clears on the next i_start.
- Reset mid-DATA after 5 beats → all valids 0 and state IDLE asynchronously; a new start with len 16 then completes normally.
